alu_cmd_ctrl: RTL and testbench
===============================

# alu_cmd_ctrl

Command sequencer between the UART receiver and the 8-bit ALU datapath (adder, subtractor, multiplier, divider, result mux, LED driver). It assembles three-byte frames (A, opcode, B) from received bytes, drives the registered operands and operator select, and sequences a multi-cycle iterative divider through a start/done handshake. It emits a one-cycle result-load strobe for the display path and reports protocol, timeout and divide-by-zero errors.

## Interface
- TIMEOUT_CYCLES, 5_000_000, maximum idle cycles allowed between bytes of one frame and while waiting for the divider (100 ms at 50 MHz); must be ≥ 2
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rx_byte  in  8  received byte, valid only when rx_valid is high
- rx_valid  in  1  one-cycle strobe from the UART receiver
- a  out  8  registered operand A
- b  out  8  registered operand B
- op  out  2  registered operator select (0 add, 1 sub, 2 mul, 3 div)
- div_start  out  1  one-cycle divider start pulse
- div_done  in  1  one-cycle divider completion pulse
- res_load  out  1  one-cycle strobe: the result mux output is valid and must be latched by the display path
- busy  out  1  high from B accept until res_load or abort
- err  out  2  sticky error code: 0 none, 1 bad opcode, 2 timeout, 3 divide by zero
- overrun  out  1  one-cycle pulse when a byte is dropped because busy is high

## Operation
- States: S_A, S_OP, S_B, S_SETTLE, S_WDIV. Reset state is S_A.
- S_A: on rx_valid, capture A into a staging register, clear err to 0, and go to S_OP.
- S_OP: on rx_valid, check rx_byte[7:2]. If it is nonzero, set err=1 and go to S_A; the frame is discarded and a/b/op are unchanged. Otherwise capture rx_byte[1:0] and go to S_B.
- S_B: on rx_valid, load a, b and op from the staging registers and rx_byte in one cycle, then assert busy.
  - If op≠3, go to S_SETTLE.
  - If op=3 and rx_byte=0, set err=3, pulse res_load, and go to S_A. The divider is not started.
  - If op=3 and rx_byte≠0, pulse div_start and go to S_WDIV.
- S_SETTLE: pulse res_load, deassert busy, go to S_A.
- S_WDIV: on div_done, pulse res_load, deassert busy, go to S_A.
- Timeout counter:
  - Clears on every accepted byte and on entry to S_WDIV.
  - Counts in S_OP, S_B and S_WDIV.
  - When it reaches TIMEOUT_CYCLES−1: set err=2, deassert busy, go to S_A. No res_load is issued.
  - It is held at 0 in S_A and S_SETTLE.
- rx_valid while busy (S_SETTLE, S_WDIV): the byte is dropped and overrun pulses.
- If div_done arrives outside S_WDIV, it is ignored.
- If div_done and the timeout expire in the same cycle, div_done wins: res_load is pulsed and err is unchanged.
- If rx_valid and the timeout expire in the same cycle in S_OP or S_B, the byte wins: it is accepted and the counter is cleared.
- Reset values: a=0, b=0, op=0, div_start=0, res_load=0, busy=0, err=0, overrun=0, state S_A, counter 0.

## Timing
- All outputs are registered, with no combinational input-to-output path.
- Let B be accepted at cycle N. Then a/b/op/busy are updated at N+1.
- Add/sub/mul: res_load is high at cycle N+2.
- Divide: div_start is high at N+1. If div_done is seen at cycle M, res_load is high at M+1.
- Divide by zero: res_load and err=3 at N+1.
- Asserting reset mid-frame or mid-divide returns to S_A immediately. Any pending result is lost, and no div_start or res_load is emitted after reset release until a new full frame arrives.
- Back-to-back frames are supported: after res_load, a new A byte may arrive on the very next cycle.

## Structure
- Package alu_ctrl_pkg holds:
  - the state enum
  - opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV
  - error-code constants ERR_NONE/ERR_BADOP/ERR_TIMEOUT/ERR_DIV0
- Sub-module alu_timeout_cnt: a parameterised saturating counter with clear and enable inputs and an expire pulse output. Its width is $clog2(TIMEOUT_CYCLES).

## Test plan
- Bytes 0x0C, 0x00, 0x05, each 10 cycles apart → a=0x0C, b=0x05, op=0. res_load occurs 2 cycles after the third byte, err=0.
- Bytes 0x64, 0x03, 0x07, with a divider model asserting div_done 9 cycles after div_start → exactly one div_start and one res_load, the res_load one cycle after div_done. busy is high for 10 cycles.
- Bytes 0x10, 0x03, 0x00 → no div_start, err=3, res_load one cycle after the B byte.
- Bytes 0x01, 0x42 → err=1 and return to S_A. The next frame 0x02, 0x02, 0x03 yields op=2 with err cleared to 0. Run with TIMEOUT_CYCLES=16.
- Byte 0x01 followed by silence → err=2 exactly 16 cycles after the byte, no res_load. Also: the divider never answers → err=2 and busy drops 16 cycles after div_start.
- A byte injected during S_WDIV → an overrun pulse, a/b/op unchanged. Reset asserted asynchronously mid-divide → all outputs are zero at once, and a late div_done produces no res_load.

Source files
------------

// File: rtl/alu_cmd_ctrl_pkg.sv
// Shared types and constants for the ALU command sequencer: FSM state
// encoding, operator-select codes and sticky error codes.
package alu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_A      = 3'd0,
        S_OP     = 3'd1,
        S_B      = 3'd2,
        S_SETTLE = 3'd3,
        S_WDIV   = 3'd4
    } state_e;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BADOP   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_DIV0    = 2'd3;

endpackage

// File: rtl/alu_cmd_ctrl_timeout_cnt.sv
// Saturating idle-cycle counter. It counts while enabled, stops at
// TIMEOUT_CYCLES-1 and flags expiry for as long as it sits there enabled.
// A clear always wins over counting, so a byte arriving in the expiry
// cycle suppresses the expire flag.
module alu_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 5_000_000,
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;

    // Idle counter: clear has priority, then saturating increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = en && !clr && (cnt_r == CNT_MAX);

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command sequencer between the UART receiver and the 8-bit ALU datapath.
// Assembles A/opcode/B frames, presents registered operands and operator,
// handshakes with the iterative divider and reports errors. Every output
// comes straight from a flop.
module alu_cmd_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic [1:0] op,
    output logic       div_start,
    input  logic       div_done,
    output logic       res_load,
    output logic       busy,
    output logic [1:0] err,
    output logic       overrun
);

    state_e     state_r;
    state_e     state_nxt_s;

    logic [7:0] a_stage_r;
    logic [7:0] a_stage_nxt_s;
    logic [1:0] op_stage_r;
    logic [1:0] op_stage_nxt_s;

    logic [7:0] a_nxt_s;
    logic [7:0] b_nxt_s;
    logic [1:0] op_nxt_s;
    logic       div_start_nxt_s;
    logic       res_load_nxt_s;
    logic       busy_nxt_s;
    logic [1:0] err_nxt_s;
    logic       overrun_nxt_s;

    logic       byte_accept_s;
    logic       cnt_clr_s;
    logic       cnt_en_s;
    logic       expire_s;

    // A byte is consumed only while a frame is being assembled; in the
    // busy states it is dropped and reported as an overrun.
    assign byte_accept_s = rx_valid &&
                           ((state_r == S_A) || (state_r == S_OP) || (state_r == S_B));
    assign cnt_clr_s     = byte_accept_s || (state_r == S_A) || (state_r == S_SETTLE);
    assign cnt_en_s      = (state_r == S_OP) || (state_r == S_B) || (state_r == S_WDIV);

    alu_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr_s),
        .en     (cnt_en_s),
        .expire (expire_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_A;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and next-output logic; pulses default low, data holds.
    always_comb begin
        state_nxt_s     = state_r;
        a_stage_nxt_s   = a_stage_r;
        op_stage_nxt_s  = op_stage_r;
        a_nxt_s         = a;
        b_nxt_s         = b;
        op_nxt_s        = op;
        busy_nxt_s      = busy;
        err_nxt_s       = err;
        div_start_nxt_s = 1'b0;
        res_load_nxt_s  = 1'b0;
        overrun_nxt_s   = 1'b0;

        case (state_r)
            S_A: begin
                if (rx_valid) begin
                    a_stage_nxt_s = rx_byte;
                    err_nxt_s     = ERR_NONE;
                    state_nxt_s   = S_OP;
                end else begin
                    state_nxt_s   = S_A;
                end
            end

            S_OP: begin
                if (rx_valid) begin
                    if (rx_byte[7:2] != 6'd0) begin
                        err_nxt_s      = ERR_BADOP;
                        state_nxt_s    = S_A;
                    end else begin
                        op_stage_nxt_s = rx_byte[1:0];
                        state_nxt_s    = S_B;
                    end
                end else if (expire_s) begin
                    err_nxt_s   = ERR_TIMEOUT;
                    state_nxt_s = S_A;
                end else begin
                    state_nxt_s = S_OP;
                end
            end

            S_B: begin
                if (rx_valid) begin
                    a_nxt_s  = a_stage_r;
                    b_nxt_s  = rx_byte;
                    op_nxt_s = op_stage_r;
                    if (op_stage_r != OP_DIV) begin
                        busy_nxt_s      = 1'b1;
                        state_nxt_s     = S_SETTLE;
                    end else if (rx_byte == 8'd0) begin
                        // Result is flagged immediately; nothing stays in flight.
                        busy_nxt_s      = 1'b0;
                        err_nxt_s       = ERR_DIV0;
                        res_load_nxt_s  = 1'b1;
                        state_nxt_s     = S_A;
                    end else begin
                        busy_nxt_s      = 1'b1;
                        div_start_nxt_s = 1'b1;
                        state_nxt_s     = S_WDIV;
                    end
                end else if (expire_s) begin
                    err_nxt_s   = ERR_TIMEOUT;
                    busy_nxt_s  = 1'b0;
                    state_nxt_s = S_A;
                end else begin
                    state_nxt_s = S_B;
                end
            end

            S_SETTLE: begin
                res_load_nxt_s = 1'b1;
                busy_nxt_s     = 1'b0;
                overrun_nxt_s  = rx_valid;
                state_nxt_s    = S_A;
            end

            S_WDIV: begin
                overrun_nxt_s = rx_valid;
                if (div_done) begin
                    res_load_nxt_s = 1'b1;
                    busy_nxt_s     = 1'b0;
                    state_nxt_s    = S_A;
                end else if (expire_s) begin
                    err_nxt_s      = ERR_TIMEOUT;
                    busy_nxt_s     = 1'b0;
                    state_nxt_s    = S_A;
                end else begin
                    state_nxt_s    = S_WDIV;
                end
            end

            default: begin
                busy_nxt_s  = 1'b0;
                state_nxt_s = S_A;
            end
        endcase
    end

    // Output and staging registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_stage_r  <= 8'd0;
            op_stage_r <= 2'd0;
            a          <= 8'd0;
            b          <= 8'd0;
            op         <= 2'd0;
            div_start  <= 1'b0;
            res_load   <= 1'b0;
            busy       <= 1'b0;
            err        <= ERR_NONE;
            overrun    <= 1'b0;
        end else begin
            a_stage_r  <= a_stage_nxt_s;
            op_stage_r <= op_stage_nxt_s;
            a          <= a_nxt_s;
            b          <= b_nxt_s;
            op         <= op_nxt_s;
            div_start  <= div_start_nxt_s;
            res_load   <= res_load_nxt_s;
            busy       <= busy_nxt_s;
            err        <= err_nxt_s;
            overrun    <= overrun_nxt_s;
        end
    end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed self-checking bench for alu_cmd_ctrl with a 16-cycle timeout.
module tb_alu_cmd_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic       div_start;
    logic       div_done;
    logic       res_load;
    logic       busy;
    logic [1:0] err;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_cnt;
    int ds_cnt;
    int rl_cnt;

    alu_cmd_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .a         (a),
        .b         (b),
        .op        (op),
        .div_start (div_start),
        .div_done  (div_done),
        .res_load  (res_load),
        .busy      (busy),
        .err       (err),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] val);
        rx_byte  = val;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"}, 32'(a), 32'h0);
        check({tag, "_b"}, 32'(b), 32'h0);
        check({tag, "_op"}, 32'(op), 32'h0);
        check({tag, "_divst"}, 32'(div_start), 32'h0);
        check({tag, "_resld"}, 32'(res_load), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_err"}, 32'(err), 32'h0);
        check({tag, "_ovr"}, 32'(overrun), 32'h0);
    endtask

    initial begin
        rst      = 1'b0;
        rx_byte  = 8'h00;
        rx_valid = 1'b0;
        div_done = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // Add frame, bytes 10 cycles apart.
        send(8'h0C);
        repeat (9) tick();
        send(8'h00);
        repeat (9) tick();
        send(8'h05);
        check("add_a", 32'(a), 32'h0C);
        check("add_b", 32'(b), 32'h05);
        check("add_op", 32'(op), 32'h0);
        check("add_busy", 32'(busy), 32'h1);
        check("add_rl_early", 32'(res_load), 32'h0);
        tick();
        check("add_rl", 32'(res_load), 32'h1);
        check("add_busy_done", 32'(busy), 32'h0);
        check("add_err", 32'(err), 32'h0);
        tick();
        check("add_rl_pulse", 32'(res_load), 32'h0);

        // Divide 100/7, divider answers 9 cycles after div_start.
        send(8'h64);
        send(8'h03);
        send(8'h07);
        check("div_start", 32'(div_start), 32'h1);
        check("div_a", 32'(a), 32'h64);
        check("div_b", 32'(b), 32'h07);
        check("div_op", 32'(op), 32'h3);
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        ds_cnt   = 1;
        rl_cnt   = 0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (busy === 1'b1) busy_cnt++;
            if (div_start === 1'b1) ds_cnt++;
            if (res_load === 1'b1) rl_cnt++;
        end
        div_done = 1'b1;
        tick();
        div_done = 1'b0;
        check("div_rl", 32'(res_load), 32'h1);
        check("div_busy_low", 32'(busy), 32'h0);
        check("div_busy_cycles", 32'(busy_cnt), 32'd10);
        check("div_start_count", 32'(ds_cnt), 32'd1);
        check("div_rl_early", 32'(rl_cnt), 32'd0);
        check("div_err", 32'(err), 32'h0);
        tick();
        check("div_rl_pulse", 32'(res_load), 32'h0);

        // Divide by zero.
        send(8'h10);
        send(8'h03);
        send(8'h00);
        check("div0_rl", 32'(res_load), 32'h1);
        check("div0_err", 32'(err), 32'h3);
        check("div0_nostart", 32'(div_start), 32'h0);
        check("div0_a", 32'(a), 32'h10);
        tick();
        check("div0_rl_pulse", 32'(res_load), 32'h0);
        check("div0_nostart2", 32'(div_start), 32'h0);
        check("div0_err_sticky", 32'(err), 32'h3);

        // Bad opcode, then a valid multiply frame.
        send(8'h01);
        check("badop_err_clr", 32'(err), 32'h0);
        send(8'h42);
        check("badop_err", 32'(err), 32'h1);
        check("badop_a_hold", 32'(a), 32'h10);
        check("badop_op_hold", 32'(op), 32'h3);
        send(8'h02);
        check("mul_err_clr", 32'(err), 32'h0);
        send(8'h02);
        send(8'h03);
        check("mul_op", 32'(op), 32'h2);
        check("mul_a", 32'(a), 32'h02);
        check("mul_b", 32'(b), 32'h03);
        tick();
        check("mul_rl", 32'(res_load), 32'h1);

        // Silence after one byte: timeout 16 cycles later.
        tick();
        send(8'h01);
        rl_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (res_load === 1'b1) rl_cnt++;
        end
        check("to_err_early", 32'(err), 32'h0);
        tick();
        check("to_err", 32'(err), 32'h2);
        check("to_no_rl", 32'(rl_cnt + int'(res_load)), 32'd0);

        // Divider never answers.
        send(8'h05);
        send(8'h03);
        send(8'h02);
        check("dto_start", 32'(div_start), 32'h1);
        repeat (15) tick();
        check("dto_busy_early", 32'(busy), 32'h1);
        check("dto_err_early", 32'(err), 32'h0);
        tick();
        check("dto_err", 32'(err), 32'h2);
        check("dto_busy", 32'(busy), 32'h0);
        check("dto_no_rl", 32'(res_load), 32'h0);

        // Byte dropped while waiting on the divider, then async reset.
        send(8'h09);
        send(8'h03);
        send(8'h03);
        tick();
        send(8'hAA);
        check("ovr_pulse", 32'(overrun), 32'h1);
        check("ovr_a", 32'(a), 32'h09);
        check("ovr_b", 32'(b), 32'h03);
        check("ovr_op", 32'(op), 32'h3);
        tick();
        check("ovr_pulse_end", 32'(overrun), 32'h0);
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        tick();
        rst = 1'b1;
        tick();
        div_done = 1'b1;
        tick();
        div_done = 1'b0;
        check("late_done_rl", 32'(res_load), 32'h0);
        tick();
        check("late_done_rl2", 32'(res_load), 32'h0);
        check("late_done_ds", 32'(div_start), 32'h0);
        check("late_done_busy", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
